// File: rtl/svga_timing_gen.sv
// svga_timing_gen
//   800x600 @ 72 Hz raster timing from a 50 MHz pixel clock.
//   col/row are the undelayed raster position handed to every pixel driver;
//   hsync/vsync/blank are delayed by PIPE_DELAY clocks so they line up with
//   the pixel drivers' output. Also provides frame strobes, a frame counter
//   and a measured frames-per-second value.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous reset, active-high
//   col          out  horizontal count, 0..H_TOTAL-1
//   row          out  vertical count, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active-high, delayed PIPE_DELAY
//   vsync        out  vertical sync, active-high, delayed PIPE_DELAY
//   blank        out  high outside the visible area, delayed PIPE_DELAY
//   frame_start  out  one-cycle strobe at (0,0)
//   vblank_start out  one-cycle strobe at (0,V_VISIBLE)
//   frame_count  out  number of vblank_start strobes, wraps
//   fps          out  vblank_start count in the last completed window
//   fps_valid    out  one-cycle strobe when fps updates
module svga_timing_gen #(
  parameter int H_VISIBLE      = 800,
  parameter int H_FRONT        = 56,
  parameter int H_SYNC         = 120,
  parameter int H_BACK         = 64,
  parameter int V_VISIBLE      = 600,
  parameter int V_FRONT        = 37,
  parameter int V_SYNC         = 6,
  parameter int V_BACK         = 23,
  parameter int PIPE_DELAY     = 2,
  parameter int ONE_SEC_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] col,
  output logic [9:0]  row,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count,
  output logic [7:0]  fps,
  output logic        fps_valid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int WIN_W   = (ONE_SEC_CYCLES > 1) ? $clog2(ONE_SEC_CYCLES) : 1;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ONE_SEC_CYCLES - 1);

  // Elaboration-time guard: timing must fit the col/row port widths.
  if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 7 ||
      ONE_SEC_CYCLES < 1) begin : g_param_check
    $error("svga_timing_gen: illegal timing parameters");
  end

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (col == H_LAST) begin
      col <= '0;
      row <= (row == V_LAST) ? 10'd0 : row + 10'd1;
    end else begin
      col <= col + 11'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Undelayed sync/blank terms
  // ---------------------------------------------------------------------
  logic hsync_raw;
  logic vsync_raw;
  logic blank_raw;

  always_comb begin
    hsync_raw = (col >= HS_FIRST) && (col <= HS_LAST);
    vsync_raw = (row >= VS_FIRST) && (row <= VS_LAST);
    blank_raw = (col >= H_VIS) || (row >= V_VIS);
  end

  // ---------------------------------------------------------------------
  // Pipeline alignment delay line
  // Reset loads the "blanked, no sync" pattern into every stage so the
  // pins stay blanked until real raster data reaches the end of the line.
  // ---------------------------------------------------------------------
  if (PIPE_DELAY == 0) begin : g_nodelay
    assign hsync = hsync_raw;
    assign vsync = vsync_raw;
    assign blank = blank_raw;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_sr;
    logic [PIPE_DELAY-1:0] vs_sr;
    logic [PIPE_DELAY-1:0] bl_sr;

    always_ff @(posedge clk) begin
      if (rst) begin
        hs_sr <= '0;
        vs_sr <= '0;
        bl_sr <= '1;
      end else begin
        hs_sr[0] <= hsync_raw;
        vs_sr[0] <= vsync_raw;
        bl_sr[0] <= blank_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_sr[i] <= hs_sr[i-1];
          vs_sr[i] <= vs_sr[i-1];
          bl_sr[i] <= bl_sr[i-1];
        end
      end
    end

    assign hsync = hs_sr[PIPE_DELAY-1];
    assign vsync = vs_sr[PIPE_DELAY-1];
    assign blank = bl_sr[PIPE_DELAY-1];
  end

  // ---------------------------------------------------------------------
  // Frame strobes. Gated by rst so a reset cycle never produces a strobe.
  // ---------------------------------------------------------------------
  assign frame_start  = !rst && (col == 11'd0) && (row == 10'd0);
  assign vblank_start = !rst && (col == 11'd0) && (row == V_VIS);

  // ---------------------------------------------------------------------
  // Frame counter and fps measurement window
  // ---------------------------------------------------------------------
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       tally;
  logic [7:0]       tally_next;
  logic             win_last;

  always_comb begin
    win_last   = (win_cnt == WIN_LAST);
    tally_next = tally;
    if (vblank_start && (tally != 8'hff)) begin
      tally_next = tally + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      tally       <= '0;
      fps         <= '0;
      fps_valid   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_count <= frame_count + 16'(vblank_start);
      fps_valid   <= win_last;
      if (win_last) begin
        // a vblank_start in the window's final cycle still belongs to it
        win_cnt <= '0;
        fps     <= tally_next;
        tally   <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        tally   <= tally_next;
      end
    end
  end

endmodule

// File: tb/tb_svga_timing_gen.sv
module tb_svga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 10, VF = 2, VS = 3, VB = 2;
  localparam int LINE = HV + HF + HS + HB;   // 30
  localparam int FL   = VV + VF + VS + VB;   // 17
  localparam int FCYC = LINE * FL;           // 510
  localparam int ONE  = 3 * FCYC;            // 3 frames per window
  localparam int PD   = 2;
  localparam int PD3  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] col,  col3;
  logic [9:0]  row,  row3;
  logic        hsync, vsync, blank, hsync3, vsync3, blank3;
  logic        frame_start, vblank_start, fps_valid;
  logic        frame_start3, vblank_start3, fps_valid3;
  logic [15:0] frame_count, frame_count3;
  logic [7:0]  fps, fps3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          t;
    logic [10:0] col;
    logic [9:0]  row;
    logic        bl, hs, vs, bl3, hs3, vs3, fs, vb, fv;
    logic [15:0] fc;
    logic [7:0]  fps;
  } exp_t;

  exp_t q[$];

  svga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_DELAY(PD), .ONE_SEC_CYCLES(ONE)
  ) u_dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .hsync(hsync), .vsync(vsync),
    .blank(blank), .frame_start(frame_start), .vblank_start(vblank_start),
    .frame_count(frame_count), .fps(fps), .fps_valid(fps_valid)
  );

  svga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_DELAY(PD3), .ONE_SEC_CYCLES(ONE)
  ) u_dut3 (
    .clk(clk), .rst(rst), .col(col3), .row(row3), .hsync(hsync3), .vsync(vsync3),
    .blank(blank3), .frame_start(frame_start3), .vblank_start(vblank_start3),
    .frame_count(frame_count3), .fps(fps3), .fps_valid(fps_valid3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (time %0t)", tag, act, exp, $time);
    end
  endtask

  // Raster terms at time index tt (cycles since reset release); negative
  // indices are the reset-loaded delay-line contents.
  function automatic void raster(input int tt, output logic b, output logic h, output logic v);
    int c, r;
    if (tt < 0) begin
      b = 1'b1; h = 1'b0; v = 1'b0;
    end else begin
      c = tt % LINE;
      r = (tt / LINE) % FL;
      h = (c >= HV + HF) && (c < HV + HF + HS);
      v = (r >= VV + VF) && (r < VV + VF + VS);
      b = (c >= HV) || (r >= VV);
    end
  endfunction

  // Reference model: expectations for each cycle pushed at the clock edge.
  initial begin
    int   m_t, m_fc, m_tally, m_fps;
    bit   m_fv, started;
    exp_t e;
    started = 0; m_t = 0; m_fc = 0; m_tally = 0; m_fps = 0; m_fv = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t = 0; m_fc = 0; m_tally = 0; m_fps = 0; m_fv = 0;
        started = 1;
      end else if (started) begin
        if (m_t % FCYC == VV * LINE) begin
          m_fc = (m_fc + 1) & 32'hffff;
          if (m_tally < 255) m_tally++;
        end
        m_fv = (m_t % ONE == ONE - 1);
        if (m_fv) begin
          m_fps   = m_tally;
          m_tally = 0;
        end
        m_t++;
      end
      if (started) begin
        e.t   = m_t;
        e.col = 11'(m_t % LINE);
        e.row = 10'((m_t / LINE) % FL);
        raster(m_t - PD,  e.bl,  e.hs,  e.vs);
        raster(m_t - PD3, e.bl3, e.hs3, e.vs3);
        e.fs  = (m_t % FCYC == 0);
        e.vb  = (m_t % FCYC == VV * LINE);
        e.fv  = m_fv;
        e.fc  = 16'(m_fc);
        e.fps = 8'(m_fps);
        q.push_back(e);
      end
    end
  end

  // Checker: pops one expectation per cycle and compares on the falling edge.
  initial begin
    exp_t e;
    bit   seen_fv;
    int   hs_run;
    seen_fv = 0;
    hs_run  = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("col",          32'(col),          32'(e.col));
        check("row",          32'(row),          32'(e.row));
        check("blank",        32'(blank),        32'(e.bl));
        check("hsync",        32'(hsync),        32'(e.hs));
        check("vsync",        32'(vsync),        32'(e.vs));
        check("blank_pd3",    32'(blank3),       32'(e.bl3));
        check("hsync_pd3",    32'(hsync3),       32'(e.hs3));
        check("vsync_pd3",    32'(vsync3),       32'(e.vs3));
        check("frame_start",  32'(frame_start),  32'(e.fs && !rst));
        check("vblank_start", 32'(vblank_start), 32'(e.vb && !rst));
        check("frame_count",  32'(frame_count),  32'(e.fc));
        check("fps",          32'(fps),          32'(e.fps));
        check("fps_valid",    32'(fps_valid),    32'(e.fv));
        if (e.fv && !seen_fv) begin
          seen_fv = 1;
          check("fps_first_is_3", 32'(fps), 32'd3);
        end
        // hsync pulse width, measured at the falling edge of the pulse
        if (hsync) hs_run++;
        else begin
          if (hs_run != 0) check("hsync_width", 32'(hs_run), 32'(HS));
          hs_run = 0;
        end
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2000) @(posedge clk);

    // mid-frame reset: find (8,5), then assert rst for one cycle
    found = 0;
    for (int i = 0; i < 2 * FCYC; i++) begin
      @(negedge clk);
      if (col == 11'd8 && row == 10'd5) begin
        found = 1;
        break;
      end
    end
    check("midframe_wait", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_col0",   32'(col),         32'd0);
    check("mid_row0",   32'(row),         32'd0);
    check("mid_fc0",    32'(frame_count), 32'd0);
    check("mid_fps0",   32'(fps),         32'd0);
    repeat (1700) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
